// File: rtl/mem_resp_mc_if.sv
// rtl/mem_resp_mc_if.sv - controller-to-memory request/response bundle for mem_resp_mc
interface mem_resp_mc_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  mem_req;
    logic                  mem_wr_en;
    logic [1:0]            mem_size;
    logic                  mem_unsigned;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wr_data;
    logic [31:0]           rd_data;
    logic                  mem_ready;
    logic                  mem_busy;
    logic                  mem_err;

    modport master (
        output mem_req, mem_wr_en, mem_size, mem_unsigned, addr, wr_data,
        input  rd_data, mem_ready, mem_busy, mem_err
    );

    modport slave (
        input  mem_req, mem_wr_en, mem_size, mem_unsigned, addr, wr_data,
        output rd_data, mem_ready, mem_busy, mem_err
    );
endinterface

// File: rtl/mem_resp_mc.sv
// rtl/mem_resp_mc.sv - word RAM responder with wait states and lane steering; MEM_MISALIGN_CHK_EN enables misalignment trapping
module mem_resp_mc #(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    mem_resp_mc_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

    state_t                state;
    logic [3:0]            wait_cnt;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [1:0]            lane_q;
    logic [1:0]            size_q;
    logic                  we_q;
    logic                  uns_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rd_q;
    logic                  ready_q;
    logic                  busy_q;
    logic                  err_q;

    logic [31:0] ram [2**DEPTH_LOG2];

    logic [31:0] word;
    logic [31:0] merged;
    logic [31:0] load_val;
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    logic        misalign;
    logic        ram_we;

    always_comb begin
        word     = ram[idx_q];
        shifted  = word >> {lane_q, 3'b000};
        b        = shifted[7:0];
        h        = lane_q[1] ? word[31:16] : word[15:0];
        merged   = word;
        load_val = word;
        case (size_q)
            2'b00: begin
                merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
                load_val = {{24{~uns_q & b[7]}}, b};
            end
            2'b01: begin
                if (lane_q[1]) merged[31:16] = wdata_q[15:0];
                else           merged[15:0]  = wdata_q[15:0];
                load_val = {{16{~uns_q & h[15]}}, h};
            end
            default: merged = wdata_q;
        endcase
    end

`ifdef MEM_MISALIGN_CHK_EN
    assign misalign = ((size_q == 2'b01) && lane_q[0]) || (size_q[1] && (lane_q != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Gated by rst so a reset landing on the ACCESS edge still aborts the store.
    assign ram_we = (state == S_ACCESS) && we_q && !misalign && !rst;

    always_ff @(posedge clk) begin
        if (ram_we) ram[idx_q] <= merged;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
            rd_q     <= 32'd0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.mem_req) begin
                        idx_q   <= bus.addr[DEPTH_LOG2+1:2];
                        lane_q  <= bus.addr[1:0];
                        size_q  <= bus.mem_size;
                        we_q    <= bus.mem_wr_en;
                        uns_q   <= bus.mem_unsigned;
                        wdata_q <= bus.wr_data;
                        busy_q  <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state    <= S_WAIT;
                            wait_cnt <= 4'd1;
                        end else begin
                            state <= S_ACCESS;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_cnt >= WAIT_N) begin
                        state    <= S_ACCESS;
                        wait_cnt <= 4'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_ACCESS: begin
                    if (!we_q) rd_q <= misalign ? 32'd0 : load_val;
                    err_q   <= misalign;
                    ready_q <= 1'b1;
                    state   <= S_RESP;
                end
                default: begin
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_data   = rd_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_busy  = busy_q;
    assign bus.mem_err   = err_q;
endmodule
